// File: rtl/enc_period_scheduler.sv
// enc_period_scheduler: snapshots NUM_CH encoder period words coherently and writes them to a
// register file one slot per wr_en/wr_ack handshake. Optional status slot: ENC_PERIOD_STATUS_EN.
module enc_period_scheduler #(
  parameter int         NUM_CH  = 4,
  parameter int         IDX_W   = 3,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [32*NUM_CH-1:0] period_in,
  input  logic                snap_req,
  input  logic                wr_ack,
  input  logic                err_clr,
  output logic                busy,
  output logic                wr_en,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [31:0]         wr_data,
  output logic                done,
  output logic                err
);

`ifdef ENC_PERIOD_STATUS_EN
  localparam int LAST = NUM_CH;
`else
  localparam int LAST = NUM_CH - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_WRITE, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]      shadow [NUM_CH];
  logic [IDX_W-1:0] idx;
  logic [7:0]       timer;
  logic             pending;
  logic             start, tmo, slot_end, last_slot;
  logic [31:0]      word_sel;

  assign start     = snap_req | pending;
  assign tmo       = (state == S_WAIT) && !wr_ack && (timer == TIMEOUT - 8'd1);
  assign slot_end  = (state == S_WAIT) && (wr_ack || tmo);
  assign last_slot = (idx == LAST_IDX);

`ifdef ENC_PERIOD_STATUS_EN
  logic [15:0] scan_cnt;
  logic [7:0]  ovf;
  logic [31:0] status_word;

  always_comb begin
    ovf = '0;
    for (int i = 0; i < NUM_CH; i++) ovf[i] = (shadow[i][15:0] == 16'h8000);
  end

  // Reports the number of the scan in progress, i.e. the count this scan's DONE will leave behind.
  assign status_word = {scan_cnt + 16'd1, 8'd0, ovf};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 scan_cnt <= '0;
    else if (state == S_DONE)   scan_cnt <= scan_cnt + 16'd1;
  end
`endif

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (idx == IDX_W'(i)) word_sel = shadow[i];
`ifdef ENC_PERIOD_STATUS_EN
    if (idx == IDX_W'(NUM_CH)) word_sel = status_word;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SNAP;
      S_SNAP:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_WAIT;
      S_WAIT:  if (slot_end) state_nxt = last_slot ? S_DONE : S_WRITE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      pending <= 1'b0;
      idx     <= '0;
      timer   <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      done <= (state == S_DONE);

      // A fresh timeout outranks a same-cycle clear.
      if (tmo)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      // Requests arriving during a scan merge into a single pending scan.
      if (state == S_IDLE) pending <= 1'b0;
      else if (snap_req)   pending <= 1'b1;

      case (state)
        S_IDLE: if (start) busy <= 1'b1;
        S_SNAP: begin
          for (int i = 0; i < NUM_CH; i++) shadow[i] <= period_in[32*i +: 32];
          idx <= '0;
        end
        S_WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= idx;
          wr_data <= word_sel;
          timer   <= '0;
        end
        S_WAIT: begin
          if (slot_end) begin
            wr_en <= 1'b0;
            if (!last_slot) idx <= idx + IDX_W'(1);
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_period_scheduler.sv
// Scoreboard bench for enc_period_scheduler; honours ENC_PERIOD_STATUS_EN for the status slot.
module tb_enc_period_scheduler;
  localparam int NUM_CH = 4;
  localparam int IDX_W  = 3;
`ifdef ENC_PERIOD_STATUS_EN
  localparam int NSLOT = NUM_CH + 1;
`else
  localparam int NSLOT = NUM_CH;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [32*NUM_CH-1:0] period_in = '0;
  logic                 snap_req = 1'b0;
  logic                 err_clr = 1'b0;
  logic                 wr_ack;
  logic                 busy, wr_en, done, err;
  logic [IDX_W-1:0]     wr_addr;
  logic [31:0]          wr_data;

  logic                 ack_en = 1'b1;
  logic                 stall_en = 1'b0;
  logic [IDX_W-1:0]     stall_addr = '0;

  int n_chk = 0, n_fail = 0, scans = 0, done_cnt = 0;
  logic [IDX_W+31:0] exp_q [$];

  // Register-file model: acks every write except one stalled address.
  assign wr_ack = ack_en && !(stall_en && wr_addr == stall_addr);

  always #5 clk = ~clk;

  enc_period_scheduler #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .TIMEOUT(8'd255)) dut (
    .clk(clk), .reset(reset), .period_in(period_in), .snap_req(snap_req),
    .wr_ack(wr_ack), .err_clr(err_clr), .busy(busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_scan(input logic [32*NUM_CH-1:0] p, input int skip);
    scans++;
    for (int i = 0; i < NUM_CH; i++)
      if (i != skip) exp_q.push_back({IDX_W'(i), p[32*i +: 32]});
`ifdef ENC_PERIOD_STATUS_EN
    begin
      logic [7:0] ovf;
      ovf = '0;
      for (int i = 0; i < NUM_CH; i++) if (p[32*i +: 16] == 16'h8000) ovf[i] = 1'b1;
      exp_q.push_back({IDX_W'(NUM_CH), scans[15:0], 8'd0, ovf});
    end
`endif
  endtask

  function automatic logic [32*NUM_CH-1:0] rand_vec();
    logic [32*NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) check_val("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  // Accepted writes are popped and compared.
  always @(negedge clk) begin
    if (reset && wr_en && wr_ack) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        logic [IDX_W+31:0] e;
        e = exp_q.pop_front();
        check_val("wr_addr", 32'(wr_addr), 32'(e[IDX_W+31:32]));
        check_val("wr_data", wr_data, e[31:0]);
      end
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cnt, d0;
    logic [32*NUM_CH-1:0] p;

    // Reset state
    #1;
    check_val("reset_outputs", {26'd0, busy, wr_en, done, err, 2'b00}, 32'd0);
    check_val("reset_addr_data", wr_data | 32'(wr_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: ramp pattern, ack tied high, latency to done
    for (int i = 0; i < NUM_CH; i++) p[32*i +: 32] = 32'h0001_0010 * (i + 1);
    period_in = p;
    push_scan(p, -1);
    pulse_snap();
    wait_done(400, cyc);
    check_val("latency", 32'(cyc + 1), 32'(2 + 2*NSLOT + 1));
    check_val("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check_val("done_pulse_width", 32'(done), 32'd0);
    check_val("busy_after", 32'(busy), 32'd0);

    // 2: period_in churns every cycle; snapshot value must win
    period_in = rand_vec();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    p = rand_vec();
    period_in = p;
    push_scan(p, -1);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      period_in = rand_vec();
      cyc++;
    end
    check_val("churn_done", 32'(done), 32'd1);
    @(negedge clk);

    // 3: stall addr 2 -> timeout, err sticky against a same-cycle clear, then clear
    check_val("err_before", 32'(err), 32'd0);
    for (int i = 0; i < NUM_CH; i++) p[32*i +: 32] = 32'hA000_0000 + 32'(i);
    period_in = p;
    stall_en = 1'b1;
    stall_addr = 3'd2;
    push_scan(p, 2);
    pulse_snap();
    cnt = 0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (wr_en && wr_addr == 3'd2) begin
        cnt++;
        if (cnt == 255) err_clr = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (err_clr) begin
        err_clr = 1'b0;
        check_val("err_clr_vs_timeout", 32'(err), 32'd1);
        check_val("tmo_wr_en_drop", 32'(wr_en), 32'd0);
      end
    end
    check_val("stall_done", 32'(done), 32'd1);
    check_val("stall_cycles", 32'(cnt), 32'd255);
    check_val("err_sticky", 32'(err), 32'd1);
    stall_en = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_val("err_cleared", 32'(err), 32'd0);

    // 4: three requests while busy merge into one follow-on scan
    p = rand_vec();
    period_in = p;
    d0 = done_cnt;
    push_scan(p, -1);
    push_scan(p, -1);
    pulse_snap();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pulse_snap();
    end
    wait_done(400, cyc);
    @(negedge clk);
    check_val("pending_restart_busy", 32'(busy), 32'd1);
    wait_done(400, cyc);
    repeat (20) @(negedge clk);
    check_val("merged_scan_count", 32'(done_cnt - d0), 32'd2);
    check_val("idle_after_merge", 32'(busy), 32'd0);

    // 5: reset while waiting on addr 1
    for (int i = 0; i < NUM_CH; i++) p[32*i +: 32] = 32'h0001_0010 * (i + 1);
    period_in = p;
    stall_en = 1'b1;
    stall_addr = 3'd1;
    exp_q.push_back({IDX_W'(0), p[31:0]});
    pulse_snap();
    cyc = 0;
    while (!(wr_en && wr_addr == 3'd1) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("reach_wait_addr1", 32'(wr_en), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("midscan_reset_ctl", {28'd0, busy, wr_en, done, err}, 32'd0);
    check_val("midscan_reset_data", wr_data | 32'(wr_addr), 32'd0);
    check_val("addr0_consumed", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stall_en = 1'b0;
    scans = 0;
    @(negedge clk);
    p = rand_vec();
    period_in = p;
    push_scan(p, -1);
    pulse_snap();
    wait_done(400, cyc);
    @(negedge clk);

`ifdef ENC_PERIOD_STATUS_EN
    // 6: overflow flag on ch1 and scan counter in the status slot
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    scans = 0;
    for (int i = 0; i < NUM_CH; i++) p[32*i +: 32] = 32'h0001_0010 * (i + 1);
    p[63:32] = 32'h1234_8000;
    period_in = p;
    for (int k = 0; k < 2; k++) begin
      push_scan(p, -1);
      pulse_snap();
      wait_done(400, cyc);
      @(negedge clk);
    end
`endif

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
